instr_fetch_unit: RTL and testbench

Fetch stage for the single-cycle MIPS datapath. Holds the program counter, fetches instruction words from instruction memory over a ready/req handshake, and presents each word to decode. Decode's 16-bit immediate field goes to `sign_ext_16_32`. The extended offset returns here to form branch targets, so this block sits directly upstream and downstream of the sign extender.

---
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the program counter, fetches one instruction word at a time over
// a req/ready handshake and holds it for decode until it is consumed.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [15:0] imm,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [1:0]  state_dbg
);

    // Handshake: a fetch is accepted in the cycle where imem_req=1 and imem_ready=1,
    // and imem_rdata is taken in that same cycle. An instruction is consumed in the
    // cycle where instr_valid=1 and stall=0; redirect inputs matter only then.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic        idle_wait;
    logic [31:0] fetch_pc;
    logic        consume;
    logic [31:0] seq_pc;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic [31:0] next_pc;

    assign consume = (state == S_HOLD) && !stall;

    // Jump outranks branch; both are relative to the address after the held instruction.
    always_comb begin
        seq_pc    = pc_plus4;
        branch_pc = pc_plus4 + (branch_offset << 2);
        jump_pc   = {pc_plus4[31:28], jump_index, 2'b00};
        next_pc   = seq_pc;
        if (jump) begin
            next_pc = jump_pc;
        end else if (branch_taken) begin
            next_pc = branch_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            idle_wait   <= 1'b0;
            fetch_pc    <= RESET_PC_A;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= 32'd0;
            imm         <= 16'd0;
            pc          <= RESET_PC_A;
            pc_plus4    <= RESET_PC_A + 32'd4;
        end else begin
            case (state)
                // The first edge after release only arms idle_wait; the request
                // goes out on the second edge.
                S_IDLE: begin
                    if (!idle_wait) begin
                        idle_wait <= 1'b1;
                    end else begin
                        idle_wait <= 1'b0;
                        imem_req  <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        imm         <= imem_rdata[15:0];
                        pc          <= fetch_pc;
                        pc_plus4    <= fetch_pc + 32'd4;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        fetch_pc    <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    idle_wait   <= 1'b0;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = fetch_pc;
    assign state_dbg = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed walk through the fetch scenarios, then random
// traffic, all compared each cycle against a transaction-level model of the fetch rules.
module tb_instr_fetch_unit;

    logic        clk_tb = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        instr_valid;
    logic [31:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    bit done = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk_tb = ~clk_tb;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk_tb),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_index   (jump_index),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .imm          (imm),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .state_dbg    (state_dbg)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks "a request is outstanding", "an instruction is held", the address being
    // fetched and the held instruction, following the fetch rules directly.
    logic        m_req, m_valid;
    logic [31:0] m_addr, m_pc, m_instr;
    int          m_wait;

    function automatic logic [31:0] redirect(input logic [31:0] cur_pc, input logic j,
                                             input logic b, input logic [31:0] off,
                                             input logic [25:0] idx);
        logic [31:0] nxt;
        nxt = cur_pc + 32'd4;
        if (j) return (nxt & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
        if (b) return nxt + off * 32'd4;
        return nxt;
    endfunction

    always @(posedge clk_tb or posedge rst) begin
        if (rst) begin
            m_req   = 1'b0;
            m_valid = 1'b0;
            m_addr  = 32'h0;
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_wait  = 2;
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) m_req = 1'b1;
        end else if (m_req && imem_ready) begin
            m_req   = 1'b0;
            m_valid = 1'b1;
            m_instr = mem_word(m_addr);
            m_pc    = m_addr;
        end else if (m_valid && !stall) begin
            m_valid = 1'b0;
            m_req   = 1'b1;
            m_addr  = redirect(m_pc, jump, branch_taken, branch_offset, jump_index);
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk_tb) begin
        if (!done) begin
            check("imem_req",    {31'd0, imem_req},    {31'd0, m_req});
            check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            check("imem_addr",   imem_addr,            m_addr);
            check("instr",       instr,                m_instr);
            check("imm",         {16'd0, imm},         {16'd0, m_instr[15:0]});
            check("pc",          pc,                   m_pc);
            check("pc_plus4",    pc_plus4,             m_pc + 32'd4);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        imem_ready    = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 32'd0;
        jump          = 1'b0;
        jump_index    = 26'd0;
    endtask

    task automatic scramble_ignored();
        branch_taken  = 1'($urandom_range(0, 1));
        jump          = 1'($urandom_range(0, 1));
        branch_offset = $urandom();
        jump_index    = 26'($urandom());
        imem_ready    = 1'($urandom_range(0, 1));
    endtask

    // One full fetch: wait for the request, optionally pin its address, answer after
    // `delay` wait cycles, stall `stalls` cycles, then consume with the given redirect.
    task automatic fetch_one(input bit chk, input logic [31:0] lit, input int delay,
                             input int stalls, input bit br, input logic [31:0] off,
                             input bit jmp, input logic [25:0] idx);
        int t;
        t = 0;
        while (!imem_req && t < 20) begin
            @(negedge clk_tb);
            t++;
        end
        if (!imem_req) check("req_timeout", 32'd0, 32'd1);
        if (chk) check("addr_lit", imem_addr, lit);
        imem_ready = 1'b0;
        repeat (delay) @(negedge clk_tb);
        imem_ready = 1'b1;
        @(negedge clk_tb);
        imem_ready = 1'b0;
        check("valid_after_ready", {31'd0, instr_valid}, 32'd1);
        stall = 1'b1;
        for (int i = 0; i < stalls; i++) begin
            scramble_ignored();
            @(negedge clk_tb);
        end
        clear_inputs();
        branch_taken  = br;
        branch_offset = off;
        jump          = jmp;
        jump_index    = idx;
        @(negedge clk_tb);
        clear_inputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] off;
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk_tb);
        check("reset_req",   {31'd0, imem_req},    32'd0);
        check("reset_valid", {31'd0, instr_valid}, 32'd0);
        check("reset_pc4",   pc_plus4,             32'h4);
        rst = 1'b0;

        // Sequential fetch, wait states, stall
        fetch_one(1, 32'h0,  0, 0, 0, 32'd0, 0, 26'd0);
        fetch_one(1, 32'h4,  0, 0, 0, 32'd0, 0, 26'd0);
        fetch_one(1, 32'h8,  3, 0, 0, 32'd0, 0, 26'd0);
        fetch_one(1, 32'hC,  0, 5, 0, 32'd0, 0, 26'd0);
        // Branches: forward to 0x40, backward, back again, forward by 3
        fetch_one(1, 32'h10, 0, 0, 1, 32'd11, 0, 26'd0);
        fetch_one(1, 32'h40, 0, 0, 1, 32'hFFFF_FFFC, 0, 26'd0);
        fetch_one(1, 32'h34, 0, 0, 1, 32'd2, 0, 26'd0);
        fetch_one(1, 32'h40, 0, 0, 1, 32'd3, 0, 26'd0);
        // Redirect inputs toggled while stalled must have no effect
        fetch_one(1, 32'h50, 0, 4, 0, 32'd0, 0, 26'd0);
        off = (32'hF000_0010 - 32'h58) >> 2;
        fetch_one(1, 32'h54, 0, 0, 1, off, 0, 26'd0);
        // Jump beats branch
        fetch_one(1, 32'hF000_0010, 0, 0, 1, 32'h0000_0100, 1, 26'h0000123);
        off = (32'hFFFF_FFFC - 32'hF000_0490) >> 2;
        fetch_one(1, 32'hF000_048C, 1, 0, 1, off, 0, 26'd0);
        // Sequential wrap from the top of the address space
        fetch_one(1, 32'hFFFF_FFFC, 0, 0, 0, 32'd0, 0, 26'd0);
        fetch_one(1, 32'h0, 0, 0, 0, 32'd0, 0, 26'd0);

        // Reset while a request is pending
        imem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_req_drop_req",   {31'd0, imem_req},    32'd0);
        check("rst_req_drop_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk_tb);
        rst = 1'b0;
        @(negedge clk_tb);
        check("idle_no_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk_tb);
        check("restart_req",  {31'd0, imem_req}, 32'd1);
        check("restart_addr", imem_addr,         32'h0);
        // Reset while holding an instruction
        imem_ready = 1'b1;
        @(negedge clk_tb);
        imem_ready = 1'b0;
        stall = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_hold_drop_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_hold_drop_req",   {31'd0, imem_req},    32'd0);
        @(negedge clk_tb);
        rst = 1'b0;
        stall = 1'b0;
        fetch_one(1, 32'h0, 0, 0, 0, 32'd0, 0, 26'd0);
        fetch_one(1, 32'h4, 2, 1, 0, 32'd0, 0, 26'd0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            imem_ready   = ($urandom_range(0, 3) != 0);
            stall        = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 2) == 0);
            jump         = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1)
                branch_offset = 32'($urandom_range(0, 64)) - 32'd32;
            else
                branch_offset = $urandom();
            jump_index = 26'($urandom());
            @(negedge clk_tb);
        end
        clear_inputs();
        @(negedge clk_tb);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
